// File: rtl/interlaken_tx_framer.sv
// Interlaken-style lane transmit framer: fractional slot pacing plus a
// four-control-word metaframe (sync, scrambler state, skip, diagnostic).
module interlaken_tx_framer #(
  parameter int META_FRAME_LEN = 16,
  parameter int PACE_NUM       = 22,
  parameter int PACE_DEN       = 67
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] DATA_IN,
  input  logic        DATA_IN_VALID,
  output logic        DATA_IN_READY,
  input  logic [57:0] SCRAM_STATE,
  input  logic        LANE_STATUS,
  input  logic        LINK_STATUS,
  output logic [63:0] DATA_OUT,
  output logic [1:0]  HEADER_OUT,
  output logic        DATA_OUT_VALID,
  output logic        FRAME_START
);
  localparam int AW = $clog2(PACE_DEN) + 1;
  localparam int PW = $clog2(META_FRAME_LEN);
  localparam logic [AW-1:0] NUM  = AW'(PACE_NUM);
  localparam logic [AW-1:0] DEN  = AW'(PACE_DEN);
  localparam logic [PW-1:0] LAST = PW'(META_FRAME_LEN - 1);
  localparam logic [PW-1:0] PMAX = PW'(META_FRAME_LEN - 2);

  localparam logic [63:0] SYNC_W = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] SKIP_W = 64'h1E1E_1E1E_1E1E_1E1E;
  localparam logic [63:0] IDLE_W = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [1:0]  HDR_D  = 2'b01;
  localparam logic [1:0]  HDR_C  = 2'b10;

  logic [AW-1:0] acc, acc_n;
  logic [PW-1:0] pos;
  logic          slot, payload;
  logic [65:0]   word;
  logic          word_fs;

  // acc < DEN always, so acc + NUM <= 2*DEN-1 fits in AW bits.
  assign acc_n   = acc + NUM;
  assign slot    = (acc_n >= DEN);
  assign payload = (pos >= PW'(3)) && (pos <= PMAX);

  assign DATA_IN_READY = !SYSTEM_RESET && slot && payload;

  always_comb begin
    word    = {HDR_C, IDLE_W};
    word_fs = 1'b0;
    if (pos == '0) begin
      word    = {HDR_C, SYNC_W};
      word_fs = 1'b1;
    end else if (pos == PW'(1)) begin
      word = {HDR_C, 6'b001010, SCRAM_STATE};
    end else if (pos == PW'(2)) begin
      word = {HDR_C, SKIP_W};
    end else if (pos == LAST) begin
      // CRC32 field left zero in this generation.
      word = {HDR_C, 6'b011001, 24'h0, LANE_STATUS, LINK_STATUS, 32'h0};
    end else if (DATA_IN_VALID) begin
      word = {HDR_D, DATA_IN};
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      acc            <= '0;
      pos            <= '0;
      DATA_OUT       <= '0;
      HEADER_OUT     <= '0;
      DATA_OUT_VALID <= 1'b0;
      FRAME_START    <= 1'b0;
    end else begin
      acc <= slot ? (acc_n - DEN) : acc_n;
      if (slot) pos <= (pos == LAST) ? '0 : pos + PW'(1);
      DATA_OUT_VALID <= slot;
      DATA_OUT       <= slot ? word[63:0]  : '0;
      HEADER_OUT     <= slot ? word[65:64] : '0;
      FRAME_START    <= slot && word_fs;
    end
  end
endmodule

// File: tb/tb_interlaken_tx_framer.sv
// Directed bench: default pacing (A), full-rate 8-word frames (B), 5-word 1/3 pacing (C).
module tb_interlaken_tx_framer;
  logic        clk, rst;
  logic [63:0] data_in;
  logic        din_valid;
  logic [57:0] scram;
  logic        lane, link;

  logic        rdy_a, vld_a, fs_a, rdy_b, vld_b, fs_b, rdy_c, vld_c, fs_c;
  logic [63:0] dout_a, dout_b, dout_c;
  logic [1:0]  hdr_a, hdr_b, hdr_c;

  int checks = 0;
  int failures = 0;

  interlaken_tx_framer u_a (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_IN(data_in), .DATA_IN_VALID(din_valid),
    .DATA_IN_READY(rdy_a), .SCRAM_STATE(scram), .LANE_STATUS(lane), .LINK_STATUS(link),
    .DATA_OUT(dout_a), .HEADER_OUT(hdr_a), .DATA_OUT_VALID(vld_a), .FRAME_START(fs_a));

  interlaken_tx_framer #(.META_FRAME_LEN(8), .PACE_NUM(1), .PACE_DEN(1)) u_b (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_IN(data_in), .DATA_IN_VALID(din_valid),
    .DATA_IN_READY(rdy_b), .SCRAM_STATE(scram), .LANE_STATUS(lane), .LINK_STATUS(link),
    .DATA_OUT(dout_b), .HEADER_OUT(hdr_b), .DATA_OUT_VALID(vld_b), .FRAME_START(fs_b));

  interlaken_tx_framer #(.META_FRAME_LEN(5), .PACE_NUM(1), .PACE_DEN(3)) u_c (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_IN(data_in), .DATA_IN_VALID(din_valid),
    .DATA_IN_READY(rdy_c), .SCRAM_STATE(scram), .LANE_STATUS(lane), .LINK_STATUS(link),
    .DATA_OUT(dout_c), .HEADER_OUT(hdr_c), .DATA_OUT_VALID(vld_c), .FRAME_START(fs_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle c (counted from reset release) has a slot iff floor(c*N/D) steps up.
  function automatic logic slot_at(input int c, input int n, input int d);
    return (((c + 1) * n) / d) > ((c * n) / d);
  endfunction

  // Expected {header, word} for a position when no payload is presented.
  function automatic logic [65:0] ctl_word(input int p, input int len, input logic [57:0] sc,
                                           input logic ln, input logic lk);
    if (p == 0)            return {2'b10, 64'h78F6_78F6_78F6_78F6};
    else if (p == 1)       return {2'b10, 6'b001010, sc};
    else if (p == 2)       return {2'b10, 64'h1E1E_1E1E_1E1E_1E1E};
    else if (p == len - 1) return {2'b10, 6'b011001, 24'h0, ln, lk, 32'h0};
    else                   return {2'b10, 64'hAAAA_AAAA_AAAA_AAAA};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    din_valid = 1'b1; data_in = 64'h1; scram = '0; lane = 1'b0; link = 1'b0;
    hold_reset();
    checks++;
    if ({vld_a, fs_a, hdr_a, dout_a} !== 68'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {vld_a, fs_a, hdr_a, dout_a});
    end
    checks++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b exp=000", {rdy_a, rdy_b, rdy_c});
    end
    checks++;
    if ({vld_b, vld_c, fs_b, fs_c} !== 4'b0000) begin
      failures++; $display("FAIL reset_valid_bc got=%b exp=0000", {vld_b, vld_c, fs_b, fs_c});
    end
  endtask

  task automatic test_idle_default();
    int k, vcnt, first;
    logic s;
    logic [65:0] e;
    din_valid = 1'b0; data_in = '0; scram = '0; lane = 1'b0; link = 1'b0;
    hold_reset();
    rst = 1'b0;
    k = 0; vcnt = 0; first = -1;
    for (int c = 0; c < 670; c++) begin
      s = slot_at(c, 22, 67);
      tick();
      checks++;
      if (vld_a !== s) begin
        failures++; $display("FAIL idle_valid c=%0d got=%b exp=%b", c + 1, vld_a, s);
      end
      if (s) begin
        e = ctl_word(k % 16, 16, scram, lane, link);
        checks++;
        if ({hdr_a, dout_a} !== e || fs_a !== (k % 16 == 0)) begin
          failures++;
          $display("FAIL idle_word c=%0d pos=%0d got=%h fs=%b exp=%h", c + 1, k % 16, {hdr_a, dout_a}, fs_a, e);
        end
        if (first < 0) first = c + 1;
        vcnt++; k++;
      end else begin
        checks++;
        if ({hdr_a, dout_a, fs_a} !== 67'h0) begin
          failures++; $display("FAIL idle_gap c=%0d got=%h exp=0", c + 1, {hdr_a, dout_a, fs_a});
        end
      end
    end
    checks++;
    if (first !== 4) begin
      failures++; $display("FAIL first_valid got=%0d exp=4", first);
    end
    checks++;
    if (vcnt !== 220) begin
      failures++; $display("FAIL valid_count got=%0d exp=220", vcnt);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    logic [63:0] exp_n;
    logic exp_r, took;
    logic [65:0] e;
    din_valid = 1'b1; data_in = 64'd1; scram = '0; lane = 1'b0; link = 1'b0;
    hold_reset();
    rst = 1'b0;
    exp_n = 64'd1;
    for (int c = 0; c < 16; c++) begin
      p = c % 8;
      exp_r = (p >= 3) && (p <= 6);
      checks++;
      if (rdy_b !== exp_r) begin
        failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, rdy_b, exp_r);
      end
      took = rdy_b && din_valid;
      tick();
      if (exp_r) begin
        e = {2'b01, exp_n};
        exp_n++;
      end else begin
        e = ctl_word(p, 8, scram, lane, link);
      end
      checks++;
      if (vld_b !== 1'b1 || {hdr_b, dout_b} !== e) begin
        failures++; $display("FAIL b2b_word c=%0d vld=%b got=%h exp=%h", c + 1, vld_b, {hdr_b, dout_b}, e);
      end
      if (took) data_in = data_in + 64'd1;
    end
    checks++;
    if (data_in !== 64'd9) begin
      failures++; $display("FAIL b2b_consumed got=%0d exp=9", data_in);
    end
  endtask

  task automatic test_control_words();
    logic [65:0] exp_t [1:8];
    exp_t[1] = {2'b10, 64'h78F6_78F6_78F6_78F6};
    exp_t[2] = {2'b10, 64'h2AAB_CDEF_0123_4567};
    exp_t[3] = {2'b10, 64'h1E1E_1E1E_1E1E_1E1E};
    exp_t[4] = {2'b10, 64'hAAAA_AAAA_AAAA_AAAA};
    exp_t[5] = {2'b10, 64'hAAAA_AAAA_AAAA_AAAA};
    exp_t[6] = {2'b10, 64'hAAAA_AAAA_AAAA_AAAA};
    exp_t[7] = {2'b10, 64'hAAAA_AAAA_AAAA_AAAA};
    exp_t[8] = {2'b10, 64'h6400_0002_0000_0000};
    din_valid = 1'b0; data_in = '0;
    scram = 58'h2AB_CDEF_0123_4567; lane = 1'b1; link = 1'b0;
    hold_reset();
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({hdr_b, dout_b} !== exp_t[c] || fs_b !== (c == 1)) begin
        failures++; $display("FAIL ctl_word c=%0d got=%h fs=%b exp=%h", c, {hdr_b, dout_b}, fs_b, exp_t[c]);
      end
    end
  endtask

  task automatic test_ready_default();
    int k, p, xfers;
    logic s, exp_r, took;
    logic [63:0] held;
    din_valid = 1'b1; data_in = 64'hC0DE_0000_0000_0001; scram = '0; lane = 1'b0; link = 1'b0;
    hold_reset();
    rst = 1'b0;
    k = 0; xfers = 0;
    for (int c = 0; c < 49; c++) begin
      s = slot_at(c, 22, 67);
      p = k % 16;
      exp_r = s && (p >= 3) && (p <= 14);
      checks++;
      if (rdy_a !== exp_r) begin
        failures++; $display("FAIL ready_pulse c=%0d got=%b exp=%b", c, rdy_a, exp_r);
      end
      took = rdy_a && din_valid;
      held = data_in;
      tick();
      if (took) begin
        checks++;
        if ({hdr_a, dout_a} !== {2'b01, held} || vld_a !== 1'b1) begin
          failures++; $display("FAIL ready_xfer c=%0d got=%h exp=%h", c + 1, {hdr_a, dout_a}, {2'b01, held});
        end
        xfers++;
        data_in = data_in + 64'd1;
      end
      if (s) k++;
    end
    checks++;
    if (xfers !== 12) begin
      failures++; $display("FAIL ready_count got=%0d exp=12", xfers);
    end
  endtask

  task automatic test_reset_mid();
    int k, found, first;
    logic s;
    logic [65:0] e;
    din_valid = 1'b0; data_in = '0; scram = '0; lane = 1'b0; link = 1'b0;
    hold_reset();
    rst = 1'b0;
    k = 0; found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (slot_at(c, 22, 67) && k == 25) found = 1;
      else begin
        if (slot_at(c, 22, 67)) k++;
        tick();
      end
    end
    checks++;
    if (found !== 1) begin
      failures++; $display("FAIL mid_reach got=%0d exp=1", found);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy_a !== 1'b0) begin
      failures++; $display("FAIL mid_ready got=%b exp=0", rdy_a);
    end
    tick();
    checks++;
    if ({vld_a, fs_a, hdr_a, dout_a} !== 68'h0) begin
      failures++; $display("FAIL mid_outputs got=%h exp=0", {vld_a, fs_a, hdr_a, dout_a});
    end
    rst = 1'b0;
    k = 0; first = -1;
    for (int c = 0; c < 60; c++) begin
      s = slot_at(c, 22, 67);
      tick();
      e = s ? ctl_word(k % 16, 16, scram, lane, link) : 66'h0;
      checks++;
      if (vld_a !== s || {hdr_a, dout_a} !== e || fs_a !== (s && k % 16 == 0)) begin
        failures++; $display("FAIL mid_seq c=%0d vld=%b got=%h exp=%h", c + 1, vld_a, {hdr_a, dout_a}, e);
      end
      if (s && first < 0) first = c + 1;
      if (s) k++;
    end
    checks++;
    if (first !== 4) begin
      failures++; $display("FAIL mid_first got=%0d exp=4", first);
    end
  endtask

  task automatic test_short_frame();
    int k, p, rcnt, rfirst;
    logic s;
    logic [65:0] e;
    din_valid = 1'b1; data_in = 64'h5555_0000_0000_00AA; scram = '0; lane = 1'b0; link = 1'b1;
    hold_reset();
    rst = 1'b0;
    k = 0; rcnt = 0; rfirst = -1;
    for (int c = 0; c < 30; c++) begin
      s = slot_at(c, 1, 3);
      p = k % 5;
      // Upstream valid toggles freely off-slot; it is asserted on every slot.
      din_valid = s ? 1'b1 : logic'(c % 2);
      #1;
      checks++;
      if (rdy_c !== (s && p == 3)) begin
        failures++; $display("FAIL short_ready c=%0d got=%b exp=%b", c, rdy_c, s && p == 3);
      end
      if (rdy_c) begin
        rcnt++;
        if (rfirst < 0) rfirst = c;
      end
      tick();
      if (!s)        e = 66'h0;
      else if (p == 3) e = {2'b01, data_in};
      else           e = ctl_word(p, 5, scram, lane, link);
      checks++;
      if (vld_c !== s || {hdr_c, dout_c} !== e || fs_c !== (s && p == 0)) begin
        failures++; $display("FAIL short_word c=%0d vld=%b got=%h exp=%h", c + 1, vld_c, {hdr_c, dout_c}, e);
      end
      if (s) k++;
    end
    checks++;
    if (rcnt !== 2 || rfirst !== 11) begin
      failures++; $display("FAIL short_ready_count got=%0d@%0d exp=2@11", rcnt, rfirst);
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; data_in = '0; scram = '0; lane = 1'b0; link = 1'b0;
    test_reset();
    test_idle_default();
    test_back_to_back();
    test_control_words();
    test_ready_default();
    test_reset_mid();
    test_short_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
